// File: rtl/ee357_muldiv_pkg.sv
// ee357_muldiv_pkg
//   Shared definitions for the multiply/divide unit: function codes (the same
//   FUNC_* values the ALU decodes) and the controller state encoding.
package ee357_muldiv_pkg;

   localparam logic [5:0] FUNC_MTHI  = 6'b010001;
   localparam logic [5:0] FUNC_MTLO  = 6'b010011;
   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } muldiv_state_t;

   // True for every function code this unit acts on.
   function automatic logic is_muldiv_func(input logic [5:0] f);
      logic ok;
      ok = 1'b0;
      case (f)
         FUNC_MTHI, FUNC_MTLO, FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ee357_cond_neg.sv
// ee357_cond_neg
//   Conditional two's-complement negation: out = neg ? -in : in.
//   Ports: in (WIDTH) value, neg (1) negate request, out (WIDTH) result.
module ee357_cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in,
   input  logic             neg,
   output logic [WIDTH-1:0] out
);

   assign out = neg ? ((~in) + WIDTH'(1)) : in;

endmodule

// File: rtl/ee357_muldiv.sv
// ee357_muldiv
//   Iterative multiply/divide unit holding the HI/LO registers.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per
//   clock; signed operations run on magnitudes and fix the sign afterwards.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start, func       request and function code (sampled when not busy)
//     opa, opb          operands (WIDTH)
//     busy, done        in-flight flag, one-cycle completion pulse
//     div_by_zero       set by the last operation if it divided by zero
//     hi, lo            HI/LO result registers (WIDTH)
module ee357_muldiv
   import ee357_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   muldiv_state_t      state_reg;
   logic [CW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] work_reg;     // {partial product | remainder, multiplier | quotient}
   logic [WIDTH-1:0]   opb_reg;      // multiplicand or divisor magnitude
   logic               is_div_reg;
   logic               neg_lo_reg;   // negate product / quotient in FIXUP
   logic               neg_hi_reg;   // negate remainder in FIXUP
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               dbz_reg;

   // Request decode
   logic is_signed, is_div, accept;
   assign is_signed = (func == FUNC_MULT) || (func == FUNC_DIV);
   assign is_div    = (func == FUNC_DIV)  || (func == FUNC_DIVU);
   assign accept    = start && is_muldiv_func(func) &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   // Operand magnitudes (identity for unsigned ops)
   logic [WIDTH-1:0] opa_mag, opb_mag;
   ee357_cond_neg #(.WIDTH(WIDTH)) u_opa_mag (
      .in(opa), .neg(is_signed & opa[WIDTH-1]), .out(opa_mag));
   ee357_cond_neg #(.WIDTH(WIDTH)) u_opb_mag (
      .in(opb), .neg(is_signed & opb[WIDTH-1]), .out(opb_mag));

   // One iteration of either algorithm
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] step_next;

   always_comb begin
      mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]} +
                  {1'b0, (work_reg[0] ? opb_reg : {WIDTH{1'b0}})};
      // Remainder shifted left with the next dividend bit; needs WIDTH+1 bits.
      div_trial = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opb_reg};
      step_next = {mul_sum, work_reg[WIDTH-1:1]};
      if (is_div_reg) begin
         if (div_diff[WIDTH])
            step_next = {div_trial[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0};
         else
            step_next = {div_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
      end
   end

   // Result sign fix
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   ee357_cond_neg #(.WIDTH(2*WIDTH)) u_prod_fix (
      .in(work_reg), .neg(neg_lo_reg), .out(prod_fix));
   ee357_cond_neg #(.WIDTH(WIDTH)) u_quot_fix (
      .in(work_reg[WIDTH-1:0]), .neg(neg_lo_reg), .out(quot_fix));
   ee357_cond_neg #(.WIDTH(WIDTH)) u_rem_fix (
      .in(work_reg[2*WIDTH-1:WIDTH]), .neg(neg_hi_reg), .out(rem_fix));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         work_reg   <= '0;
         opb_reg    <= '0;
         is_div_reg <= 1'b0;
         neg_lo_reg <= 1'b0;
         neg_hi_reg <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         dbz_reg    <= 1'b0;
      end else if (accept) begin
         dbz_reg <= 1'b0;
         if (func == FUNC_MTHI) begin
            hi_reg    <= opa;
            state_reg <= ST_DONE;
         end else if (func == FUNC_MTLO) begin
            lo_reg    <= opa;
            state_reg <= ST_DONE;
         end else if (is_div && (opb == '0)) begin
            hi_reg    <= opa;
            lo_reg    <= '1;
            dbz_reg   <= 1'b1;
            state_reg <= ST_DONE;
         end else begin
            // Both algorithms start from {0, opa magnitude} with opb magnitude aside.
            work_reg   <= {{WIDTH{1'b0}}, opa_mag};
            opb_reg    <= opb_mag;
            is_div_reg <= is_div;
            neg_lo_reg <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            neg_hi_reg <= is_signed & opa[WIDTH-1];
            cnt_reg    <= CW'(WIDTH);
            state_reg  <= ST_RUN;
         end
      end else begin
         case (state_reg)
            ST_RUN: begin
               work_reg <= step_next;
               cnt_reg  <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1))
                  state_reg <= ST_FIXUP;
            end
            ST_FIXUP: begin
               if (is_div_reg) begin
                  hi_reg <= rem_fix;
                  lo_reg <= quot_fix;
               end else begin
                  {hi_reg, lo_reg} <= prod_fix;
               end
               state_reg <= ST_DONE;
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign busy        = (state_reg == ST_RUN) || (state_reg == ST_FIXUP);
   assign done        = (state_reg == ST_DONE);
   assign div_by_zero = dbz_reg;
   assign hi          = hi_reg;
   assign lo          = lo_reg;

endmodule

// File: tb/tb_ee357_muldiv.sv
// tb_ee357_muldiv
//   Directed-vector bench for ee357_muldiv at WIDTH=32 plus a WIDTH=8 instance.
module tb_ee357_muldiv;

   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  func;
   logic [31:0] opa, opb;
   logic        busy, done, dbz;
   logic [31:0] hi, lo;

   logic        start8;
   logic [5:0]  func8;
   logic [7:0]  opa8, opb8;
   logic        busy8, done8, dbz8;
   logic [7:0]  hi8, lo8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ee357_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .opa(opa), .opb(opb),
      .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo));

   ee357_muldiv #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .func(func8), .opa(opa8), .opb(opb8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8));

   // Issues one request and waits for done. lat = edges after the accept edge
   // until done is seen (-1 on timeout); busy_cnt = cycles with busy high;
   // hold_ok = hi/lo unchanged while busy.
   task automatic run32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output bit hold_ok);
      logic [31:0] pre_hi, pre_lo;
      @(negedge clk);
      pre_hi = hi; pre_lo = lo;
      start = 1'b1; func = f; opa = a; opb = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cnt = 0; hold_ok = 1'b1;
      while (!done && lat < 200) begin
         if (busy) begin
            busy_cnt++;
            if (hi !== pre_hi || lo !== pre_lo) hold_ok = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; func = '0; opa = '0; opb = '0;
      start8 = 1'b0; func8 = '0; opa8 = '0; opb8 = '0;
      repeat (2) @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", dbz); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo); end
      checks++; if (busy8 !== 1'b0 || hi8 !== 8'h0 || lo8 !== 8'h0) begin errors++; $display("FAIL reset_w8 got busy=%0b hi=%h lo=%h want 0 00 00", busy8, hi8, lo8); end
      $display("reset: busy=%0b done=%0b dbz=%0b hi=%h lo=%h", busy, done, dbz, hi, lo);
      @(negedge clk); rst = 1'b0;
   endtask

   // Runs one timed operation and checks result, flag, latency and busy profile.
   task automatic test_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dbz, input int exp_lat);
      int lat, bc; bit hold;
      run32(f, a, b, lat, bc, hold);
      $display("%s: opa=%h opb=%h -> hi=%h lo=%h dbz=%0b lat=%0d busy=%0d", name, a, b, hi, lo, dbz, lat, bc);
      checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi got %h want %h", name, hi, exp_hi); end
      checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo got %h want %h", name, lo, exp_lo); end
      checks++; if (dbz !== exp_dbz) begin errors++; $display("FAIL %s_dbz got %0b want %0b", name, dbz, exp_dbz); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
      // busy is high after the accept edge through the last RUN edge
      checks++; if (bc != (exp_lat == 0 ? 0 : exp_lat)) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, (exp_lat == 0 ? 0 : exp_lat)); end
      checks++; if (!hold) begin errors++; $display("FAIL %s_hilo_hold got changed want stable", name); end
   endtask

   task automatic test_multiply();
      test_op("multu", F_MULTU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 1'b0, 33);
      test_op("mult",  F_MULT,  32'hffffffff, 32'h00000002, 32'hffffffff, 32'hfffffffe, 1'b0, 33);
   endtask

   task automatic test_divide();
      test_op("div_neg",    F_DIV,  32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd, 1'b0, 33);
      test_op("div_minneg", F_DIV,  32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b0, 33);
      test_op("divu_small", F_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000e, 1'b0, 33);
      test_op("divu_big",   F_DIVU, 32'hffffffff, 32'h0000000a, 32'h00000005, 32'h19999999, 1'b0, 33);
   endtask

   task automatic test_div_by_zero();
      test_op("divu_zero", F_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hffffffff, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      start = 1'b1; func = F_MTHI; opa = 32'h12345678; opb = 32'h0;
      @(posedge clk); #1;
      $display("mthi: hi=%h done=%0b dbz=%0b", hi, done, dbz);
      checks++; if (done !== 1'b1 || hi !== 32'h12345678) begin errors++; $display("FAIL mthi got done=%0b hi=%h want 1 12345678", done, hi); end
      checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL mthi_dbz_clear got %0b want 0", dbz); end
      func = F_MTLO; opa = 32'h9abcdef0;
      @(posedge clk); #1;
      start = 1'b0;
      $display("mtlo: hi=%h lo=%h done=%0b", hi, lo, done);
      checks++; if (done !== 1'b1 || lo !== 32'h9abcdef0 || hi !== 32'h12345678) begin errors++; $display("FAIL mtlo got done=%0b hi=%h lo=%h want 1 12345678 9abcdef0", done, hi, lo); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mt_idle got done=%0b busy=%0b want 0 0", done, busy); end
   endtask

   task automatic test_reset_mid_op();
      int done_seen;
      @(negedge clk);
      start = 1'b1; func = F_DIVU; opa = 32'd1000; opb = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %0b want 1", busy); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      $display("mid-op reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%0b done=%0b want 0 0", busy, done); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got %h_%h want 0_0", hi, lo); end
      @(negedge clk); rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", done_seen); end
   endtask

   task automatic test_ignored_start();
      int lat;
      @(negedge clk);
      start = 1'b1; func = F_MULTU; opa = 32'd3; opb = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         if (lat == 5) begin
            start = 1'b1; func = F_MULTU; opa = 32'd7; opb = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      if (!done) lat = -1;
      $display("ignored start: hi=%h lo=%h lat=%0d", hi, lo, lat);
      checks++; if (hi !== 32'h0 || lo !== 32'h0000000f) begin errors++; $display("FAIL ignored_result got %h_%h want 00000000_0000000f", hi, lo); end
      checks++; if (lat != 33) begin errors++; $display("FAIL ignored_latency got %0d want 33", lat); end
   endtask

   task automatic test_bad_func();
      @(negedge clk);
      start = 1'b1; func = 6'b100000; opa = 32'hdeadbeef; opb = 32'h1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      $display("bad func: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL badfunc_ctrl got busy=%0b done=%0b want 0 0", busy, done); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0000000f) begin errors++; $display("FAIL badfunc_hilo got %h_%h want 00000000_0000000f", hi, lo); end
   endtask

   task automatic test_width8();
      int lat, bc;
      @(negedge clk);
      start8 = 1'b1; func8 = F_MULTU; opa8 = 8'hff; opb8 = 8'hff;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0; bc = 0;
      while (!done8 && lat < 100) begin
         if (busy8) bc++;
         @(posedge clk); #1;
         lat++;
      end
      if (!done8) lat = -1;
      $display("w8 multu: hi=%h lo=%h lat=%0d busy=%0d", hi8, lo8, lat, bc);
      checks++; if (hi8 !== 8'hfe || lo8 !== 8'h01) begin errors++; $display("FAIL w8_result got %h_%h want fe_01", hi8, lo8); end
      checks++; if (lat != 9) begin errors++; $display("FAIL w8_latency got %0d want 9", lat); end
      checks++; if (bc != 9) begin errors++; $display("FAIL w8_busy_cycles got %0d want 9", bc); end
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_div_by_zero();
      test_back_to_back();
      test_reset_mid_op();
      test_ignored_start();
      test_bad_func();
      test_width8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
